// File: rtl/spi_mm_pkg.sv
// Shared types and sizes for the SPI matrix-multiply host.
package spi_mm_pkg;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int WR_BITS        = 8 * BYTE_W;
  localparam int RD_BITS        = WORD_W;
  localparam int DEF_CLK_DIV    = 4;
  localparam int DEF_GAP_CYCLES = 8;

  typedef enum logic [2:0] {
    IDLE, SETUP, WRITE, GAP, READ, TAIL, FINISH
  } state_t;
endpackage

// File: rtl/spi_matmul_host_if.sv
// Request/result handshake and SPI pins of the matrix-multiply host.
interface spi_matmul_host_if;
  import spi_mm_pkg::*;

  logic              start;
  logic [WORD_W-1:0] a_in;
  logic [WORD_W-1:0] b_in;
  logic [WORD_W-1:0] c_out;
  logic              busy;
  logic              done;
  logic              spi_clk;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              spi_miso;

  modport master (
    input  start, a_in, b_in, spi_miso,
    output c_out, busy, done, spi_clk, spi_cs_n, spi_mosi
  );

  modport slave (
    output start, a_in, b_in, spi_miso,
    input  c_out, busy, done, spi_clk, spi_cs_n, spi_mosi
  );
endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK half-period counter: phase-start/phase-end ticks and the registered SCLK level.
module spi_sclk_gen
  import spi_mm_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic run_nxt,
  input  logic hold_hi,
  output logic ph_start,
  output logic ph_end,
  output logic sclk
);
  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign ph_start = run && (cnt == '0);
  assign ph_end   = run && (cnt == CW'(CLK_DIV - 1));

  // SCLK follows the next state so it never glitches across state boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      cnt <= (run && !ph_end) ? cnt + 1'b1 : '0;
      if (!run_nxt)    sclk <= hold_hi;
      else if (!run)   sclk <= 1'b0;
      else if (ph_end) sclk <= ~sclk;
    end
  end
endmodule

// File: rtl/spi_matmul_host.sv
// SPI controller for the 2x2 matrix-multiply peripheral: writes A and B, waits, reads C.
module spi_matmul_host
  import spi_mm_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input logic                clk,
  input logic                rst_n,
  spi_matmul_host_if.master  bus
);
  state_t              state, state_nxt;
  logic [15:0]         cnt;
  logic [WR_BITS-1:0]  tx_sr;
  logic [RD_BITS-1:0]  rx_sr;
  logic [WORD_W-1:0]   c_q;
  logic                cs_n_q, mosi_q;
  logic                run, run_nxt, ph_start, ph_end, sclk, bit_end;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .run_nxt  (run_nxt),
    .hold_hi  (state_nxt == GAP),
    .ph_start (ph_start),
    .ph_end   (ph_end),
    .sclk     (sclk)
  );

  assign run          = state inside {SETUP, WRITE, READ};
  assign run_nxt      = state_nxt inside {SETUP, WRITE, READ};
  assign bit_end      = ph_end && sclk;
  assign bus.spi_clk  = sclk;
  assign bus.spi_cs_n = cs_n_q;
  assign bus.spi_mosi = mosi_q;
  assign bus.c_out    = c_q;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == FINISH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // cnt holds rising edges seen in WRITE/READ and elapsed cycles in GAP/TAIL.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SETUP;
      SETUP:   if (ph_end) state_nxt = WRITE;
      WRITE:   if (bit_end && cnt == 16'(WR_BITS)) state_nxt = GAP;
      GAP:     if (cnt == 16'(GAP_CYCLES - 1)) state_nxt = READ;
      READ:    if (bit_end && cnt == 16'(RD_BITS - 1)) state_nxt = TAIL;
      TAIL:    if (cnt == 16'(CLK_DIV - 1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      tx_sr  <= '0;
      rx_sr  <= '0;
      c_q    <= '0;
      cs_n_q <= 1'b1;
      mosi_q <= 1'b0;
    end else begin
      cs_n_q <= (state_nxt == IDLE) || (state_nxt == FINISH);
      if (state_nxt != state)
        cnt <= '0;
      else if (state == GAP || state == TAIL || (ph_start && sclk))
        cnt <= cnt + 16'd1;

      case (state)
        IDLE: if (bus.start) begin
          tx_sr  <= {bus.a_in, bus.b_in};
          mosi_q <= bus.a_in[WORD_W-1];
        end
        WRITE: if (bit_end) begin
          tx_sr  <= tx_sr << 1;
          mosi_q <= (cnt == 16'(WR_BITS)) ? 1'b0 : tx_sr[WR_BITS-2];
        end
        GAP:  if (cnt == 16'(GAP_CYCLES - 1)) rx_sr <= {rx_sr[RD_BITS-2:0], bus.spi_miso};
        READ: if (bit_end) rx_sr <= {rx_sr[RD_BITS-2:0], bus.spi_miso};
        TAIL: if (cnt == 16'(CLK_DIV - 1)) c_q <= rx_sr;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_matmul_host.sv
// Bench for spi_matmul_host: behavioural SPI peripheral plus arithmetic matrix reference.
module tb_spi_matmul_host;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  spi_matmul_host_if bus0 ();
  spi_matmul_host_if bus1 ();

  spi_matmul_host dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  spi_matmul_host #(.CLK_DIV(2), .GAP_CYCLES(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  wire [1:0]       sclk_w = {bus1.spi_clk, bus0.spi_clk};
  wire [1:0]       cs_w   = {bus1.spi_cs_n, bus0.spi_cs_n};
  wire [1:0]       mosi_w = {bus1.spi_mosi, bus0.spi_mosi};
  wire [1:0]       miso_w;
  wire [1:0][63:0] mon_rx;
  wire [1:0][31:0] mon_rises;

  assign bus0.spi_miso = miso_w[0];
  assign bus1.spi_miso = miso_w[1];

  // 2x2 product of row-major byte matrices, each element truncated to 8 bits.
  function automatic logic [31:0] mm_ref(input logic [31:0] a, input logic [31:0] b);
    int x[4], y[4], c[4];
    for (int i = 0; i < 4; i++) begin
      x[i] = int'((a >> (24 - 8 * i)) & 32'hFF);
      y[i] = int'((b >> (24 - 8 * i)) & 32'hFF);
    end
    c[0] = x[0] * y[0] + x[1] * y[2];
    c[1] = x[0] * y[1] + x[1] * y[3];
    c[2] = x[2] * y[0] + x[3] * y[2];
    c[3] = x[2] * y[1] + x[3] * y[3];
    return {c[0][7:0], c[1][7:0], c[2][7:0], c[3][7:0]};
  endfunction

  // Peripheral: samples MOSI on rising SCLK, shifts the result out on falling SCLK.
  for (genvar g = 0; g < 2; g++) begin : g_per
    logic [63:0] rx = '0;
    logic [31:0] tx = '0;
    int          cnt = 0;
    int          rises = 0;
    logic        miso = 1'b0;
    logic        sclk_q = 1'b0;
    logic        cs_q = 1'b1;

    always @(sclk_w[g] or cs_w[g]) begin
      if (!cs_w[g] && cs_q) begin
        cnt   = 0;
        rises = 0;
      end
      if (!cs_w[g] && sclk_w[g] && !sclk_q) begin
        rises++;
        if (cnt < 64) begin
          rx = {rx[62:0], mosi_w[g]};
          cnt++;
          if (cnt == 64) begin
            tx   = mm_ref(rx[63:32], rx[31:0]);
            miso = tx[31];
          end
        end
      end
      if (!cs_w[g] && !sclk_w[g] && sclk_q && cnt == 64) begin
        tx   = tx << 1;
        miso = tx[31];
      end
      sclk_q = sclk_w[g];
      cs_q   = cs_w[g];
    end

    assign miso_w[g]    = miso;
    assign mon_rx[g]    = rx;
    assign mon_rises[g] = rises;
  end

  task automatic drive(input int g, input logic s, input logic [31:0] a, input logic [31:0] b);
    if (g == 0) begin bus0.start = s; bus0.a_in = a; bus0.b_in = b; end
    else        begin bus1.start = s; bus1.a_in = a; bus1.b_in = b; end
  endtask

  function automatic logic [31:0] c_of(input int g);
    return (g == 0) ? bus0.c_out : bus1.c_out;
  endfunction

  // Runs one transaction, observing once per cycle at the falling clock edge.
  task automatic run_txn(input int g, input logic [31:0] a, input logic [31:0] b,
                         input int win, input int restart_at, input int rst_at,
                         output int lat, output int ndone, output bit busy_ok,
                         output bit idle_after, output logic cs_first,
                         output logic mosi_first, output logic cs_rst);
    logic dn, bz;
    lat = -1; ndone = 0; busy_ok = 1'b1; idle_after = 1'b0;
    cs_first = 1'b1; mosi_first = 1'b0; cs_rst = 1'b0;
    @(negedge clk);
    drive(g, 1'b1, a, b);
    @(negedge clk);
    drive(g, 1'b0, a, b);
    for (int n = 1; n <= win; n++) begin
      dn = (g == 0) ? bus0.done : bus1.done;
      bz = (g == 0) ? bus0.busy : bus1.busy;
      if (n == 1) begin
        cs_first   = cs_w[g];
        mosi_first = mosi_w[g];
      end
      if (lat < 0 && !bz) busy_ok = 1'b0;
      if (dn) begin
        ndone++;
        if (lat < 0) lat = n;
      end
      if (n == win) idle_after = !bz;
      if (restart_at > 0 && n == restart_at)     drive(g, 1'b1, a, b);
      if (restart_at > 0 && n == restart_at + 1) drive(g, 1'b0, a, b);
      if (rst_at > 0 && n == rst_at) begin
        rst_n = 1'b0;
        #1 cs_rst = cs_w[g];
      end
      if (rst_at > 0 && n == rst_at + 3) rst_n = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    drive(0, 1'b0, '0, '0);
    drive(1, 1'b0, '0, '0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checks++; if (cs_w[g] !== 1'b1) begin errors++; $display("FAIL reset_cs_n[%0d]: got %b want 1", g, cs_w[g]); end
      checks++; if (sclk_w[g] !== 1'b0) begin errors++; $display("FAIL reset_sclk[%0d]: got %b want 0", g, sclk_w[g]); end
      checks++; if (mosi_w[g] !== 1'b0) begin errors++; $display("FAIL reset_mosi[%0d]: got %b want 0", g, mosi_w[g]); end
      checks++; if (c_of(g) !== 32'h0) begin errors++; $display("FAIL reset_c_out[%0d]: got %h want 0", g, c_of(g)); end
    end
    checks++; if ({bus1.busy, bus0.busy} !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b want 00", {bus1.busy, bus0.busy}); end
    checks++; if ({bus1.done, bus0.done} !== 2'b00) begin errors++; $display("FAIL reset_done: got %b want 00", {bus1.done, bus0.done}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_known_vectors();
    int          tg[3]  = '{0, 0, 1};
    logic [31:0] ta[3]  = '{32'h01020304, 32'hFFFFFFFF, 32'h01020304};
    logic [31:0] tb_[3] = '{32'h05060708, 32'hFFFFFFFF, 32'h05060708};
    logic [31:0] tc[3]  = '{32'h13162B32, 32'h02020202, 32'h13162B32};
    int          tl[3]  = '{773, 773, 387};
    int lat, nd; bit bok, idl; logic csf, mf, csr;
    for (int i = 0; i < 3; i++) begin
      run_txn(tg[i], ta[i], tb_[i], tl[i] + 30, 0, 0, lat, nd, bok, idl, csf, mf, csr);
      checks++; if (c_of(tg[i]) !== tc[i]) begin errors++; $display("FAIL known_c_out[%0d]: got %h want %h", i, c_of(tg[i]), tc[i]); end
      checks++; if (lat != tl[i]) begin errors++; $display("FAIL known_latency[%0d]: got %0d want %0d", i, lat, tl[i]); end
      checks++; if (nd != 1) begin errors++; $display("FAIL known_done_count[%0d]: got %0d want 1", i, nd); end
      checks++; if (!bok) begin errors++; $display("FAIL known_busy[%0d]: got gap want continuous", i); end
      checks++; if (csf !== 1'b0) begin errors++; $display("FAIL known_cs_first[%0d]: got %b want 0", i, csf); end
      checks++; if (mf !== ta[i][31]) begin errors++; $display("FAIL known_mosi_first[%0d]: got %b want %b", i, mf, ta[i][31]); end
      checks++; if (mon_rises[tg[i]] != 32'd95) begin errors++; $display("FAIL known_sclk_rises[%0d]: got %0d want 95", i, mon_rises[tg[i]]); end
    end
  endtask

  task automatic test_mosi_pattern();
    int lat, nd; bit bok, idl; logic csf, mf, csr;
    run_txn(0, 32'h80000000, 32'h0, 800, 0, 0, lat, nd, bok, idl, csf, mf, csr);
    checks++; if (mon_rx[0] !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL mosi_pattern: got %h want 8000000000000000", mon_rx[0]); end
    checks++; if (mon_rises[0] != 32'd95) begin errors++; $display("FAIL mosi_rises: got %0d want 95", mon_rises[0]); end
    checks++; if (c_of(0) !== 32'h0) begin errors++; $display("FAIL mosi_c_out: got %h want 0", c_of(0)); end
  endtask

  task automatic test_random();
    int lat, nd; bit bok, idl; logic csf, mf, csr;
    logic [31:0] a, b;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom;
      run_txn(i % 2, a, b, (i % 2 == 0) ? 800 : 420, 0, 0, lat, nd, bok, idl, csf, mf, csr);
      checks++; if (c_of(i % 2) !== mm_ref(a, b)) begin errors++; $display("FAIL random_c_out[%0d]: got %h want %h", i, c_of(i % 2), mm_ref(a, b)); end
      checks++; if (lat != ((i % 2 == 0) ? 773 : 387)) begin errors++; $display("FAIL random_latency[%0d]: got %0d want %0d", i, lat, (i % 2 == 0) ? 773 : 387); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, nd; bit bok, idl; logic csf, mf, csr;
    logic [31:0] a, b, exp;
    a = $urandom; b = $urandom; exp = mm_ref(a, b);
    run_txn(0, a, b, 900, 100, 0, lat, nd, bok, idl, csf, mf, csr);
    checks++; if (nd != 1) begin errors++; $display("FAIL b2b_done_count: got %0d want 1", nd); end
    checks++; if (lat != 773) begin errors++; $display("FAIL b2b_latency: got %0d want 773", lat); end
    checks++; if (!bok) begin errors++; $display("FAIL b2b_busy: got gap want continuous"); end
    checks++; if (!idl) begin errors++; $display("FAIL b2b_idle_after: got busy want idle"); end
    checks++; if (c_of(0) !== exp) begin errors++; $display("FAIL b2b_c_out: got %h want %h", c_of(0), exp); end
    drive(0, 1'b0, $urandom, $urandom);
    repeat (20) @(negedge clk);
    checks++; if (c_of(0) !== exp) begin errors++; $display("FAIL b2b_c_hold: got %h want %h", c_of(0), exp); end
  endtask

  task automatic test_reset_abort();
    int lat, nd; bit bok, idl; logic csf, mf, csr;
    logic [31:0] a, b;
    run_txn(0, $urandom, $urandom, 900, 0, 300, lat, nd, bok, idl, csf, mf, csr);
    checks++; if (csr !== 1'b1) begin errors++; $display("FAIL abort_cs_n: got %b want 1", csr); end
    checks++; if (nd != 0) begin errors++; $display("FAIL abort_done_count: got %0d want 0", nd); end
    checks++; if (c_of(0) !== 32'h0) begin errors++; $display("FAIL abort_c_out: got %h want 0", c_of(0)); end
    a = $urandom; b = $urandom;
    run_txn(0, a, b, 800, 0, 0, lat, nd, bok, idl, csf, mf, csr);
    checks++; if (c_of(0) !== mm_ref(a, b)) begin errors++; $display("FAIL abort_next_c_out: got %h want %h", c_of(0), mm_ref(a, b)); end
    checks++; if (lat != 773) begin errors++; $display("FAIL abort_next_latency: got %0d want 773", lat); end
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_mosi_pattern();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_matmul_host.md
SPI_MATMUL_HOST -- requirements
Module: spi_matmul_host

Interface
REQ-001 Parameter CLK_DIV, default 4, clk cycles per SCLK half-period; legal values >= 2.
REQ-002 Parameter GAP_CYCLES, default 8, extra clk cycles SCLK is held high between write and read phases; legal values >= 4.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to run one transaction; sampled only in IDLE.
REQ-006 a_in  input  32  matrix A, A0 in [31:24], A1 [23:16], A2 [15:8], A3 [7:0]; row-major 2x2.
REQ-007 b_in  input  32  matrix B, same packing as a_in.
REQ-008 c_out  output  32  result low bytes, C00 in [31:24], C01, C10, C11 in [7:0].
REQ-009 busy  output  1  high from the cycle after an accepted start until the cycle done is asserted, inclusive.
REQ-010 done  output  1  one-cycle pulse; c_out is valid from this cycle on.
REQ-011 spi_clk  output  1  SCLK, idles low.
REQ-012 spi_cs_n  output  1  chip select, active-low, idles high.
REQ-013 spi_mosi  output  1  serial data to the peripheral, MSB-first.
REQ-014 spi_miso  input  1  serial data from the peripheral.

Function
REQ-015 The block SHALL be the SPI controller for the 2x2 matrix-multiply peripheral: it writes 8 bytes (A0..A3, B0..B3), then reads 4 bytes (C00, C01, C10, C11).
REQ-016 The FSM SHALL have the states IDLE, SETUP, WRITE, GAP, READ, TAIL, and FINISH.
REQ-017 IDLE: start=1 at cycle t SHALL latch a_in/b_in and enter SETUP with spi_cs_n=0, busy=1, and spi_mosi=A0[7] at t+1.
REQ-018 A bit period SHALL be a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles; SETUP is the low phase of bit 0.
REQ-019 WRITE: spi_mosi SHALL change only on the first cycle of a low phase and stay stable through the following high phase; 64 bit periods in the order A0..A3, B0..B3, each byte MSB-first.
REQ-020 GAP: after the 64th high phase, spi_clk SHALL stay high for GAP_CYCLES more cycles; spi_mosi SHALL be 0. The peripheral computes during this time.
REQ-021 On the last GAP cycle, the block SHALL sample spi_miso into result bit 31 (C00[7]).
REQ-022 READ: 31 further bit periods; spi_miso SHALL be sampled on the last cycle of each high phase and shifted into the result MSB-first, filling bits 30..0.
REQ-023 TAIL: spi_clk SHALL drive low for CLK_DIV cycles with spi_cs_n still 0; spi_cs_n SHALL then return to 1 in FINISH.
REQ-024 FINISH (one cycle): done=1, c_out SHALL update to the 32 sampled bits in the same cycle, spi_cs_n=1, and busy=1; the next state is IDLE.
REQ-025 Timing at defaults: spi_cs_n falls at t+1; done rises at t+1+512+8+248+4 = t+773.
REQ-026 start while busy SHALL be ignored, with no queuing; c_out SHALL hold its value until the next FINISH.
REQ-027 The block SHALL take result values as received; there is no width extension. C values are the low 8 bits of the 16-bit products computed by the peripheral.
REQ-028 spi_clk, spi_cs_n, and spi_mosi SHALL be driven directly from flops, so they are glitch-free.

Reset
REQ-029 While rst_n=0, the block SHALL force state=IDLE, spi_cs_n=1, spi_clk=0, spi_mosi=0, busy=0, done=0, c_out=0, and clear all counters and shift registers.
REQ-030 Reset mid-transaction SHALL abort immediately: spi_cs_n goes high asynchronously, and no done pulse is produced for the aborted transaction.

Structure
REQ-031 Shared package spi_mm_pkg SHALL hold the FSM state enum, the byte and word widths, and the default CLK_DIV and GAP_CYCLES values.
REQ-032 Sub-module spi_sclk_gen SHALL hold the half-period counter and produce the phase-start and phase-end ticks plus the SCLK level; the FSM and data path stay in spi_matmul_host.

Verification
REQ-033 With a behavioural peripheral model and A=0x01020304, B=0x05060708: after start, c_out SHALL equal 0x13162B32 with one done pulse.
REQ-034 With A=0xFFFFFFFF and B=0xFFFFFFFF: c_out SHALL equal 0x02020202 (0x1FC02 truncated to 8 bits).
REQ-035 With A=0x80000000 and B=0: the monitor SHALL see a MOSI 1 only on the first rising edge of spi_clk, with 63 zeros after it; there SHALL be exactly 64+31 rising edges of spi_clk per transaction.
REQ-036 A second start pulse at t+100: it SHALL be ignored, with one transaction, one done pulse, and busy continuous.
REQ-037 rst_n low at t+300, then a new start: spi_cs_n SHALL go high within the reset, no done pulse SHALL occur, and the next transaction SHALL produce a correct c_out.
REQ-038 With CLK_DIV=2 and GAP_CYCLES=4, rerunning REQ-033: the same c_out SHALL result, and done SHALL occur at t+1+256+4+124+2.
